// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between three writeback
//   requesters (0: ALU, 1: RAM load, 2: I/O/stack) using round-robin
//   arbitration with a valid/ready handshake. Every grant becomes a
//   registered one-cycle write strobe. A "pair" request writes two adjacent
//   registers on consecutive cycles (low byte to addr, high byte to addr+1)
//   without another requester interleaving.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-low
//   req_valid  : per-requester pending write
//   req_pair   : per-requester two-byte pair write
//   req_addr   : 4 bits per requester
//   req_data   : 16 bits per requester ([7:0] low byte, [15:8] high byte)
//   req_ready  : one-hot combinational accept
//   w_enable   : register file write strobe (registered)
//   w_addr     : register file write address (registered)
//   w_data     : register file write data (registered)
//   busy       : high while the high byte of a pair is pending
//   err_addr   : sticky illegal-address flag
//   err_src    : requester that caused the most recent illegal address
//   err_clr    : clears err_addr / err_src (a same-cycle error wins)
module regfile_write_arbiter #(
  parameter int NUM_REGS = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [2:0]  req_pair,
  input  logic [11:0] req_addr,
  input  logic [47:0] req_data,
  output logic [2:0]  req_ready,
  output logic        w_enable,
  output logic [3:0]  w_addr,
  output logic [7:0]  w_data,
  output logic        busy,
  output logic        err_addr,
  output logic [1:0]  err_src,
  input  logic        err_clr
);

  localparam int NUM_REQ = 3;

  // Address limits widened by one bit so NUM_REGS up to 16 compares cleanly.
  localparam logic [4:0] LIM_SINGLE = 5'(NUM_REGS);
  localparam logic [4:0] LIM_PAIR   = 5'(NUM_REGS - 1);

  typedef enum logic {IDLE = 1'b0, HI = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        we_q, we_d;
  logic [3:0]  wa_q, wa_d;
  logic [7:0]  wd_q, wd_d;
  logic [3:0]  hi_addr_q, hi_addr_d;
  logic [7:0]  hi_data_q, hi_data_d;
  logic        err_q, err_d;
  logic [1:0]  src_q, src_d;

  logic        gnt_vld;
  logic [1:0]  gnt_idx;
  logic [3:0]  sel_addr;
  logic [15:0] sel_data;
  logic        sel_pair;
  logic        sel_legal;

  // (base + off) mod NUM_REQ for base, off in 0..2.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    return (s >= 3'(NUM_REQ)) ? 2'(s - 3'(NUM_REQ)) : s[1:0];
  endfunction

  // Round-robin search starting at ptr. Iterating from the farthest
  // candidate down lets the nearest valid requester overwrite the result.
  // No grant while in reset so req_ready stays low during reset.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    if (state_q == IDLE && rst) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid[rr_idx(ptr_q, 2'(k))]) begin
          gnt_vld = 1'b1;
          gnt_idx = rr_idx(ptr_q, 2'(k));
        end
      end
    end
  end

  assign sel_addr  = req_addr[{gnt_idx, 2'b00} +: 4];
  assign sel_data  = req_data[{gnt_idx, 4'b0000} +: 16];
  assign sel_pair  = req_pair[gnt_idx];
  // A pair needs addr+1 to exist as well; no wrap to register 0.
  assign sel_legal = sel_pair ? ({1'b0, sel_addr} < LIM_PAIR)
                              : ({1'b0, sel_addr} < LIM_SINGLE);

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    we_d      = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    hi_addr_d = hi_addr_q;
    hi_data_d = hi_data_q;
    err_d     = err_q;
    src_d     = src_q;

    if (err_clr) begin
      err_d = 1'b0;
      src_d = 2'd0;
    end

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          ptr_d = rr_idx(gnt_idx, 2'd1);
          if (sel_legal) begin
            we_d = 1'b1;
            wa_d = sel_addr;
            wd_d = sel_data[7:0];
            if (sel_pair) begin
              // High byte captured now; the requester is free after accept.
              state_d   = HI;
              hi_addr_d = sel_addr + 4'd1;
              hi_data_d = sel_data[15:8];
            end
          end else begin
            // Error assignment follows the clear so a same-cycle error wins.
            err_d = 1'b1;
            src_d = gnt_idx;
          end
        end
      end
      HI: begin
        we_d    = 1'b1;
        wa_d    = hi_addr_q;
        wd_d    = hi_data_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      we_q      <= 1'b0;
      wa_q      <= 4'd0;
      wd_q      <= 8'd0;
      hi_addr_q <= 4'd0;
      hi_data_q <= 8'd0;
      err_q     <= 1'b0;
      src_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      we_q      <= we_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      hi_addr_q <= hi_addr_d;
      hi_data_q <= hi_data_d;
      err_q     <= err_d;
      src_q     <= src_d;
    end
  end

  assign w_enable = we_q;
  assign w_addr   = wa_q;
  assign w_data   = wd_q;
  assign busy     = (state_q == HI);
  assign err_addr = err_q;
  assign err_src  = src_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int NR = 11;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_pair;
  logic [11:0] req_addr;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        w_enable;
  logic [3:0]  w_addr;
  logic [7:0]  w_data;
  logic        busy;
  logic        err_addr;
  logic [1:0]  err_src;
  logic        err_clr;

  regfile_write_arbiter #(.NUM_REGS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_pair  (req_pair),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .w_enable  (w_enable),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .busy      (busy),
    .err_addr  (err_addr),
    .err_src   (err_src),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of directed stimulus: inputs, expected ready in that cycle,
  // expected registered outputs after the following rising edge.
  typedef struct {
    logic [2:0]  v;
    logic [2:0]  p;
    logic [11:0] a;
    logic [47:0] d;
    logic        clr;
    logic [2:0]  rdy;
    logic        we;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic        bsy;
    logic        ea;
    logic [1:0]  es;
  } vec_t;

  vec_t vecs[20];

  // Behavioural model: queue of pending register writes, round-robin pointer.
  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wq[$];
  int         m_ptr;
  logic [3:0] m_wa;
  logic [7:0] m_wd;
  logic       m_ea;
  logic [1:0] m_es;

  logic        rv[3];
  logic        rp[3];
  logic [3:0]  ra[3];
  logic [15:0] rd[3];

  initial begin
    // ---- directed table ----
    // T0 req0 single addr3 0x5A
    vecs[0]  = '{3'b001, 3'b000, 12'h003, 48'h0000_0000_005A, 1'b0, 3'b001, 1'b1, 4'd3,  8'h5A, 1'b0, 1'b0, 2'd0};
    // T1 req2 single addr5 0x55 (ptr=1 -> searches 1,2,0)
    vecs[1]  = '{3'b100, 3'b000, 12'h500, 48'h0055_0000_0000, 1'b0, 3'b100, 1'b1, 4'd5,  8'h55, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{3'b000, 3'b000, 12'h000, 48'h0,              1'b0, 3'b000, 1'b0, 4'd5,  8'h55, 1'b0, 1'b0, 2'd0};
    // T3..T8 all valid singles: addr 1/2/4, data 11/22/44
    vecs[3]  = '{3'b111, 3'b000, 12'h421, 48'h0044_0022_0011, 1'b0, 3'b001, 1'b1, 4'd1,  8'h11, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{3'b111, 3'b000, 12'h421, 48'h0044_0022_0011, 1'b0, 3'b010, 1'b1, 4'd2,  8'h22, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{3'b111, 3'b000, 12'h421, 48'h0044_0022_0011, 1'b0, 3'b100, 1'b1, 4'd4,  8'h44, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{3'b111, 3'b000, 12'h421, 48'h0044_0022_0011, 1'b0, 3'b001, 1'b1, 4'd1,  8'h11, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{3'b111, 3'b000, 12'h421, 48'h0044_0022_0011, 1'b0, 3'b010, 1'b1, 4'd2,  8'h22, 1'b0, 1'b0, 2'd0};
    vecs[8]  = '{3'b111, 3'b000, 12'h421, 48'h0044_0022_0011, 1'b0, 3'b100, 1'b1, 4'd4,  8'h44, 1'b0, 1'b0, 2'd0};
    // T9 req1 pair addr9 0x0ABC, req2 single addr6 0x77 waiting
    vecs[9]  = '{3'b110, 3'b010, 12'h690, 48'h0077_0ABC_0000, 1'b0, 3'b010, 1'b1, 4'd9,  8'hBC, 1'b1, 1'b0, 2'd0};
    // T10 HI: no accept, high byte strobed; req1 changed its data
    vecs[10] = '{3'b100, 3'b000, 12'h600, 48'h0077_FFFF_0000, 1'b0, 3'b000, 1'b1, 4'd10, 8'h0A, 1'b0, 1'b0, 2'd0};
    vecs[11] = '{3'b100, 3'b000, 12'h600, 48'h0077_0000_0000, 1'b0, 3'b100, 1'b1, 4'd6,  8'h77, 1'b0, 1'b0, 2'd0};
    vecs[12] = '{3'b000, 3'b000, 12'h000, 48'h0,              1'b0, 3'b000, 1'b0, 4'd6,  8'h77, 1'b0, 1'b0, 2'd0};
    // T13 req2 single addr11 illegal
    vecs[13] = '{3'b100, 3'b000, 12'hB00, 48'h0099_0000_0000, 1'b0, 3'b100, 1'b0, 4'd6,  8'h77, 1'b0, 1'b1, 2'd2};
    // T14 req0 pair addr10 illegal
    vecs[14] = '{3'b001, 3'b001, 12'h00A, 48'h0000_0000_1234, 1'b0, 3'b001, 1'b0, 4'd6,  8'h77, 1'b0, 1'b1, 2'd0};
    // T15 clear
    vecs[15] = '{3'b000, 3'b000, 12'h000, 48'h0,              1'b1, 3'b000, 1'b0, 4'd6,  8'h77, 1'b0, 1'b0, 2'd0};
    // T16 clear together with req1 illegal single addr15: error wins
    vecs[16] = '{3'b010, 3'b000, 12'h0F0, 48'h0000_0033_0000, 1'b1, 3'b010, 1'b0, 4'd6,  8'h77, 1'b0, 1'b1, 2'd1};
    vecs[17] = '{3'b000, 3'b000, 12'h000, 48'h0,              1'b0, 3'b000, 1'b0, 4'd6,  8'h77, 1'b0, 1'b1, 2'd1};
    // T18 single to highest legal register 10
    vecs[18] = '{3'b001, 3'b000, 12'h00A, 48'h0000_0000_00A5, 1'b0, 3'b001, 1'b1, 4'd10, 8'hA5, 1'b0, 1'b1, 2'd1};
    vecs[19] = '{3'b000, 3'b000, 12'h000, 48'h0,              1'b0, 3'b000, 1'b0, 4'd10, 8'hA5, 1'b0, 1'b1, 2'd1};

    // ---- reset values ----
    rst       = 1'b0;
    req_valid = 3'b111;
    req_pair  = 3'b000;
    req_addr  = 12'h123;
    req_data  = '0;
    err_clr   = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_we",    32'(w_enable),  32'd0);
    chk("rst_waddr", 32'(w_addr),    32'd0);
    chk("rst_wdata", 32'(w_data),    32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_err",   32'({err_addr, err_src}), 32'd0);
    @(negedge clk);
    req_valid = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid = vecs[i].v;
      req_pair  = vecs[i].p;
      req_addr  = vecs[i].a;
      req_data  = vecs[i].d;
      err_clr   = vecs[i].clr;
      #1;
      chk($sformatf("t%0d_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_we", i),    32'(w_enable), 32'(vecs[i].we));
      chk($sformatf("t%0d_waddr", i), 32'(w_addr),   32'(vecs[i].wa));
      chk($sformatf("t%0d_wdata", i), 32'(w_data),   32'(vecs[i].wd));
      chk($sformatf("t%0d_busy", i),  32'(busy),     32'(vecs[i].bsy));
      chk($sformatf("t%0d_err", i),   32'({err_addr, err_src}), 32'({vecs[i].ea, vecs[i].es}));
    end

    // ---- reset asserted during HI of a pair ----
    @(negedge clk);
    req_valid = 3'b001;
    req_pair  = 3'b001;
    req_addr  = 12'h000;
    req_data  = 48'h0000_0000_1234;
    err_clr   = 1'b0;
    #1;
    chk("hi_rst_ready", 32'(req_ready), 32'b001);
    @(posedge clk);
    #1;
    chk("hi_rst_lo_we",   32'(w_enable), 32'd1);
    chk("hi_rst_lo_data", 32'(w_data),   32'h34);
    chk("hi_rst_busy",    32'(busy),     32'd1);
    req_valid = 3'b011;
    req_pair  = 3'b000;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_we",    32'(w_enable), 32'd0);
    chk("async_rst_waddr", 32'(w_addr),   32'd0);
    chk("async_rst_wdata", 32'(w_data),   32'd0);
    chk("async_rst_busy",  32'(busy),     32'd0);
    chk("async_rst_err",   32'({err_addr, err_src}), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 3'b000;
    @(posedge clk);
    #1;
    chk("post_rst_no_hi", 32'(w_enable), 32'd0);
    @(negedge clk);
    req_valid = 3'b011;
    req_addr  = 12'h032;
    req_data  = 48'h0000_0077_0066;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b001);
    @(posedge clk);
    #1;
    chk("post_rst_we",    32'(w_enable), 32'd1);
    chk("post_rst_waddr", 32'(w_addr),   32'd2);
    chk("post_rst_wdata", 32'(w_data),   32'h66);

    // ---- randomized traffic against the reference model ----
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    m_ptr = 0;
    wq.delete();
    m_wa = '0;
    m_wd = '0;
    m_ea = 1'b0;
    m_es = '0;
    for (int r = 0; r < 3; r++) begin
      rv[r] = 1'b0; rp[r] = 1'b0; ra[r] = '0; rd[r] = '0;
    end

    begin
      int g;
      g = -1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic [2:0] exp_rdy;
        logic       exp_we;
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
          if (r == g || !rv[r]) begin
            if ($urandom_range(0, 2) != 0) begin
              rv[r] = 1'b1;
              rp[r] = ($urandom_range(0, 2) == 0);
              ra[r] = 4'($urandom_range(0, 12));
              rd[r] = 16'($urandom);
            end else begin
              rv[r] = 1'b0;
            end
          end
        end
        for (int r = 0; r < 3; r++) begin
          req_valid[r]           = rv[r];
          req_pair[r]            = rp[r];
          req_addr[4*r +: 4]     = ra[r];
          req_data[16*r +: 16]   = rd[r];
        end
        err_clr = ($urandom_range(0, 15) == 0);
        #1;
        g = -1;
        if (wq.size() == 0) begin
          for (int k = 2; k >= 0; k--) begin
            if (rv[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
          end
        end
        exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
        chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rnd_busy",  32'(busy),      32'(wq.size() != 0));
        if (err_clr) begin
          m_ea = 1'b0;
          m_es = 2'd0;
        end
        if (g >= 0) begin
          m_ptr = (g + 1) % 3;
          if ((rp[g] && int'(ra[g]) < NR - 1) || (!rp[g] && int'(ra[g]) < NR)) begin
            wq.push_back('{ra[g], rd[g][7:0]});
            if (rp[g]) wq.push_back('{ra[g] + 4'd1, rd[g][15:8]});
          end else begin
            m_ea = 1'b1;
            m_es = 2'(g);
          end
        end
        @(posedge clk);
        #1;
        exp_we = 1'b0;
        if (wq.size() > 0) begin
          wr_t w;
          w      = wq.pop_front();
          exp_we = 1'b1;
          m_wa   = w.a;
          m_wd   = w.d;
        end
        chk("rnd_we",    32'(w_enable), 32'(exp_we));
        chk("rnd_waddr", 32'(w_addr),   32'(m_wa));
        chk("rnd_wdata", 32'(w_data),   32'(m_wd));
        chk("rnd_err",   32'({err_addr, err_src}), 32'({m_ea, m_es}));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
